cond_logic: RTL and testbench

- Conditional-execution stage directly downstream of the control-unit decoder in the single-cycle ARM datapath.
- Holds the architectural NZCV flags register and evaluates the instruction condition field against it.
- Gates the decoder's PCS/RegW/MemW/BL requests into the actual PCSrc/RegWrite/MemWrite/LinkWrite strobes.
- Updates the flags selectively per FlagW.

---
 rtl/cond_pkg.sv | 39 +++
 rtl/cond_check.sv | 52 +++++
 rtl/cond_logic.sv | 84 ++++++++
 tb/tb_cond_logic.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cond_pkg.sv
// -----------------------------------------------------------------------------
// cond_pkg
// Shared constants for the conditional-execution stage of the single-cycle ARM
// datapath. It defines the following:
//   - the sixteen instruction condition-field encodings (Cond = instr[31:28])
//   - the bit positions of N, Z, C and V inside the 4-bit flags vector
//   - the bit positions of the two FlagW update requests from the decoder
// -----------------------------------------------------------------------------
package cond_pkg;

  // Condition-field encodings
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // Bit positions inside {N,Z,C,V}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // Bit positions inside FlagW
  localparam int FW_NZ = 1;
  localparam int FW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// -----------------------------------------------------------------------------
// cond_check
// This is a purely combinational evaluator. It checks the instruction
// condition field against the registered NZCV flags.
//   Cond   in  4  instruction condition field
//   Flags  in  4  registered {N,Z,C,V}
//   CondEx out 1  1 when the instruction is allowed to execute
// Parameter COND_NV_PASS sets the result for the reserved 1111 encoding.
// -----------------------------------------------------------------------------
module cond_check
  import cond_pkg::*;
#(
  parameter bit COND_NV_PASS = 1'b0
) (
  input  logic [3:0] Cond,
  input  logic [3:0] Flags,
  output logic       CondEx
);

  logic n, z, c, v;

  assign n = Flags[FLAG_N];
  assign z = Flags[FLAG_Z];
  assign c = Flags[FLAG_C];
  assign v = Flags[FLAG_V];

  // Decode the condition field against the flags.
  // The signed comparisons (GE/LT/GT/LE) treat N==V as "not less than".
  always_comb begin
    CondEx = 1'b0;
    case (Cond)
      COND_EQ: CondEx = z;
      COND_NE: CondEx = ~z;
      COND_CS: CondEx = c;
      COND_CC: CondEx = ~c;
      COND_MI: CondEx = n;
      COND_PL: CondEx = ~n;
      COND_VS: CondEx = v;
      COND_VC: CondEx = ~v;
      COND_HI: CondEx = c & ~z;
      COND_LS: CondEx = ~c | z;
      COND_GE: CondEx = ~(n ^ v);
      COND_LT: CondEx = n ^ v;
      COND_GT: CondEx = ~z & ~(n ^ v);
      COND_LE: CondEx = z | (n ^ v);
      COND_AL: CondEx = 1'b1;
      COND_NV: CondEx = COND_NV_PASS;
      default: CondEx = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// -----------------------------------------------------------------------------
// cond_logic
// This is the conditional-execution stage that sits after the control decoder.
// It performs three jobs:
//   - It holds the architectural NZCV register.
//   - It evaluates the instruction condition against that register.
//   - It gates the decoder write requests into the real write strobes.
// Ports:
//   clk       in  1  rising-edge clock
//   reset     in  1  synchronous active-high reset
//   En        in  1  instruction valid; 0 suppresses strobes and flag updates
//   Cond      in  4  instruction condition field
//   ALUFlags  in  4  ALU {N,Z,C,V} of the current instruction
//   FlagW     in  2  [1] update N,Z  [0] update C,V
//   PCS/RegW/MemW/BL in 1  decoder write requests
//   PCSrc/RegWrite/MemWrite/LinkWrite out 1  gated strobes
//   CondEx    out 1  condition passed
//   Flags     out 4  registered {N,Z,C,V}
// -----------------------------------------------------------------------------
module cond_logic
  import cond_pkg::*;
#(
  parameter logic [3:0] FLAG_RESET   = 4'b0000,
  parameter bit         COND_NV_PASS = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       En,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       BL,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       LinkWrite,
  output logic       CondEx,
  output logic [3:0] Flags
);

  logic [3:0] flags;
  logic       gate;
  logic       nzload;
  logic       cvload;

  // The condition is evaluated only from the registered flags. A
  // flag-setting instruction therefore influences only the instruction
  // that follows it.
  cond_check #(
    .COND_NV_PASS(COND_NV_PASS)
  ) u_cond_check (
    .Cond  (Cond),
    .Flags (flags),
    .CondEx(CondEx)
  );

  // AND gating with a zero term forces a 0 even when the request is X.
  // This keeps the strobes clean during stalls and reset.
  assign gate      = CondEx & En & ~reset;
  assign PCSrc     = PCS  & gate;
  assign RegWrite  = RegW & gate;
  assign MemWrite  = MemW & gate;
  assign LinkWrite = BL   & gate;

  assign nzload = FlagW[FW_NZ] & CondEx & En;
  assign cvload = FlagW[FW_CV] & CondEx & En;

  // Two independently enabled halves of the flags register.
  // Reset takes priority over an update in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags <= FLAG_RESET;
    end else begin
      if (nzload) flags[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
      if (cvload) flags[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
    end
  end

  assign Flags = flags;

endmodule

// File: tb/tb_cond_logic.sv
// -----------------------------------------------------------------------------
// tb_cond_logic
// This is the self-checking bench for cond_logic. A reference model tracks
// the NZCV flags and predicts CondEx, the four strobes and the next flags
// value. The model works from the architectural meaning of each condition.
// -----------------------------------------------------------------------------
module tb_cond_logic;

  localparam logic [3:0] FLAG_RESET   = 4'b0000;
  localparam bit         COND_NV_PASS = 1'b0;

  logic       clk;
  logic       reset;
  logic       En;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCS, RegW, MemW, BL;
  logic       PCSrc, RegWrite, MemWrite, LinkWrite, CondEx;
  logic [3:0] Flags;

  int         testsRun;
  int         testsFailed;
  logic [3:0] modelFlags;

  cond_logic #(
    .FLAG_RESET  (FLAG_RESET),
    .COND_NV_PASS(COND_NV_PASS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .En       (En),
    .Cond     (Cond),
    .ALUFlags (ALUFlags),
    .FlagW    (FlagW),
    .PCS      (PCS),
    .RegW     (RegW),
    .MemW     (MemW),
    .BL       (BL),
    .PCSrc    (PCSrc),
    .RegWrite (RegWrite),
    .MemWrite (MemWrite),
    .LinkWrite(LinkWrite),
    .CondEx   (CondEx),
    .Flags    (Flags)
  );

  // Free-running clock with a 10-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference condition evaluation, written from the meaning of each mnemonic.
  // "Signed greater or equal" means the N and V flags agree.
  function automatic bit refPass(input int c, input logic [3:0] f);
    bit n, z, cy, v;
    n  = f[3];
    z  = f[2];
    cy = f[1];
    v  = f[0];
    case (c)
      0:  return z;
      1:  return !z;
      2:  return cy;
      3:  return !cy;
      4:  return n;
      5:  return !n;
      6:  return v;
      7:  return !v;
      8:  return cy && !z;
      9:  return !cy || z;
      10: return n == v;
      11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      14: return 1'b1;
      default: return COND_NV_PASS;
    endcase
  endfunction

  // Single comparison point: count, and report a mismatch
  task automatic checkOutput(input string tag, input logic [3:0] actual, input logic [3:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Drive one instruction for one clock.
  // The task checks the combinational outputs mid-cycle. It then advances
  // the model at the edge and checks the registered flags just afterwards.
  // It is entered and left 1 time unit after a rising edge.
  task automatic applyStimulus(input string tag, input bit rst, input bit en,
                               input logic [3:0] c, input logic [3:0] alu,
                               input logic [1:0] fw, input bit pcs,
                               input bit regw, input bit memw, input bit bl);
    bit pass, g;
    reset = rst; En = en; Cond = c; ALUFlags = alu; FlagW = fw;
    PCS = pcs; RegW = regw; MemW = memw; BL = bl;
    #4;
    if (!$isunknown(modelFlags)) begin
      pass = refPass(int'(c), modelFlags);
      g    = pass && en && !rst;
      checkOutput({tag, ".condex"}, {3'b0, CondEx}, {3'b0, pass});
      checkOutput({tag, ".strobes"}, {PCSrc, RegWrite, MemWrite, LinkWrite},
                  {pcs && g, regw && g, memw && g, bl && g});
    end else begin
      pass = 1'b0;
      if (rst || !en)
        checkOutput({tag, ".strobes"}, {PCSrc, RegWrite, MemWrite, LinkWrite}, 4'b0000);
    end
    @(posedge clk);
    if (rst) modelFlags = FLAG_RESET;
    else if (en && pass) begin
      if (fw[1]) modelFlags[3:2] = alu[3:2];
      if (fw[0]) modelFlags[1:0] = alu[1:0];
    end
    #1;
    checkOutput({tag, ".flags"}, Flags, modelFlags);
  endtask

  // Load an arbitrary flags value with an always-executing flag-setting op
  task automatic loadFlags(input logic [3:0] f);
    applyStimulus("load", 0, 1, 4'b1110, f, 2'b11, 0, 0, 0, 0);
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    modelFlags  = 4'bxxxx;
    reset = 1'b1; En = 1'b0; Cond = 4'b0; ALUFlags = 4'b0; FlagW = 2'b0;
    PCS = 1'b0; RegW = 1'b0; MemW = 1'b0; BL = 1'b0;
    @(posedge clk);
    #1;

    // Reset while an update and a register write are requested
    applyStimulus("reset", 1, 1, 4'b1110, 4'b1111, 2'b11, 0, 1, 0, 0);
    checkOutput("reset_flags", Flags, 4'b0000);

    // Partial updates: NZ half, then CV half
    applyStimulus("nz_upd", 0, 1, 4'b1110, 4'b0100, 2'b10, 0, 0, 0, 0);
    checkOutput("nz_only", Flags, 4'b0100);
    applyStimulus("cv_upd", 0, 1, 4'b1110, 4'b0011, 2'b01, 0, 0, 0, 0);
    checkOutput("cv_only", Flags, 4'b0111);

    // Condition sweep over every flags value and every condition
    for (int f = 0; f < 16; f++) begin
      loadFlags(4'(f));
      for (int c = 0; c < 16; c++)
        applyStimulus("sweep", 0, 1, 4'(c), 4'($urandom), 2'b00, 1, 1, 1, 1);
    end
    loadFlags(4'b1001);
    applyStimulus("ge", 0, 1, 4'b1010, 4'b0000, 2'b00, 0, 0, 0, 0);
    checkOutput("ge_1001", {3'b0, CondEx}, 4'b0001);
    applyStimulus("lt", 0, 1, 4'b1011, 4'b0000, 2'b00, 0, 0, 0, 0);
    checkOutput("lt_1001", {3'b0, CondEx}, 4'b0000);

    // A failed condition blocks both the strobes and the flag update
    loadFlags(4'b0000);
    applyStimulus("failcond", 0, 1, 4'b0000, 4'b1111, 2'b11, 1, 1, 1, 0);
    checkOutput("failcond_flags", Flags, 4'b0000);

    // BL with a passing condition raises PCSrc and LinkWrite together
    loadFlags(4'b0100);
    applyStimulus("bl", 0, 1, 4'b0000, 4'b0000, 2'b00, 1, 0, 0, 1);
    checkOutput("bl_pc_link", {2'b00, PCSrc, LinkWrite}, 4'b0011);

    // CMP-style op followed by BEQ. The CMP cycle's condition ignores its
    // own ALUFlags; only BEQ sees the new Z.
    loadFlags(4'b0000);
    applyStimulus("cmp", 0, 1, 4'b1110, 4'b0100, 2'b11, 0, 0, 0, 0);
    applyStimulus("beq", 0, 1, 4'b0000, 4'b0000, 2'b00, 1, 0, 0, 0);
    checkOutput("beq_taken", {3'b0, PCSrc}, 4'b0001);
    applyStimulus("nobypass", 0, 1, 4'b0001, 4'b0000, 2'b11, 0, 1, 0, 0);
    checkOutput("nobypass_flags", Flags, 4'b0100);

    // A stall holds everything; the same op then completes once enabled
    applyStimulus("stall", 0, 0, 4'b1110, 4'b1010, 2'b11, 1, 1, 1, 1);
    checkOutput("stall_flags", Flags, 4'b0100);
    applyStimulus("resume", 0, 1, 4'b1110, 4'b1010, 2'b11, 1, 1, 1, 1);
    checkOutput("resume_flags", Flags, 4'b1010);

    // Reset during a flag update wins
    applyStimulus("rst_upd", 1, 1, 4'b1110, 4'b1111, 2'b11, 1, 1, 1, 1);

    // Unknown requests stay suppressed while stalled or in reset
    reset = 1'b0; En = 1'b0; Cond = 4'bx; PCS = 1'bx; RegW = 1'bx; MemW = 1'bx; BL = 1'bx;
    #2;
    checkOutput("xsafe_stall", {PCSrc, RegWrite, MemWrite, LinkWrite}, 4'b0000);
    reset = 1'b1; En = 1'b1;
    #2;
    checkOutput("xsafe_reset", {PCSrc, RegWrite, MemWrite, LinkWrite}, 4'b0000);
    @(posedge clk);
    modelFlags = FLAG_RESET;
    #1;

    // Randomised instruction stream with occasional stalls and resets
    for (int i = 0; i < 1500; i++) begin
      applyStimulus("rand", ($urandom_range(31) == 0), ($urandom_range(3) != 0),
                    4'($urandom), 4'($urandom), 2'($urandom),
                    1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
